vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen.sv | 148 ++++++++++++++
 tb/tb_vga_pattern_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four test patterns (solid, colour bars, checker, moving bar).
// Pattern selection and colour are latched once per frame so a frame is never torn.
module vga_pattern_gen #(
  parameter int   H_DISPLAY = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_DISPLAY = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter int   CLK_DIV   = 2,
  parameter int   RGB_W     = 3,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   CHK_LOG2  = 5,
  parameter int   BAR_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [RGB_W-1:0] color,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [RGB_W-1:0] rgb,
  output logic             frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = RGB_W / 3;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DISP   = HW'(H_DISPLAY);
  localparam logic [HW-1:0] HS_START = HW'(H_DISPLAY + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] OFF_LAST = HW'(H_DISPLAY - 1);
  localparam logic [HW-1:0] BAR_LEN  = HW'(BAR_W);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DISP   = VW'(V_DISPLAY);
  localparam logic [VW-1:0] VS_START = VW'(V_DISPLAY + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DW-1:0]    r_div;
  logic [HW-1:0]    r_h;
  logic [VW-1:0]    r_v;
  logic [HW-1:0]    r_off;
  logic [1:0]       r_mode;
  logic [RGB_W-1:0] r_color;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic [RGB_W-1:0] r_rgb;
  logic             r_frame_tick;

  logic             w_p_tick;
  logic             w_h_end;
  logic             w_frame_end;
  logic             w_vis;
  logic [7:1]       w_bar_ge;
  logic [2:0]       w_bar_idx;
  logic [RGB_W-1:0] w_bar_rgb;
  logic [HW-1:0]    w_dist;
  logic [RGB_W-1:0] w_pix;

  assign w_p_tick    = (r_div == DIV_LAST);
  assign w_h_end     = w_p_tick && (r_h == H_LAST);
  assign w_frame_end = w_h_end && (r_v == V_LAST);
  assign w_vis       = (r_h < H_DISP) && (r_v < V_DISP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div        <= '0;
      r_h          <= '0;
      r_v          <= '0;
      r_off        <= '0;
      r_mode       <= '0;
      r_color      <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_div <= w_p_tick ? '0 : r_div + DW'(1);
      if (w_p_tick)
        r_h <= (r_h == H_LAST) ? '0 : r_h + HW'(1);
      if (w_h_end)
        r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
      if (w_frame_end) begin
        r_mode  <= mode;
        r_color <= color;
        r_off   <= (r_off == OFF_LAST) ? '0 : r_off + HW'(1);
      end
      r_frame_tick <= w_frame_end;
    end
  end

  // Bar index x*8/H_DISPLAY via constant thresholds ceil(k*H_DISPLAY/8).
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_bar_thr
      localparam int THR = (gi * H_DISPLAY + 7) / 8;
      assign w_bar_ge[gi] = (r_h >= HW'(THR));
    end
  endgenerate

  always_comb begin
    w_bar_idx = 3'd0;
    for (int k = 1; k < 8; k++)
      if (w_bar_ge[k]) w_bar_idx = 3'(k);
  end

  assign w_bar_rgb = {{CW{w_bar_idx[2]}}, {CW{w_bar_idx[1]}}, {CW{w_bar_idx[0]}}};

  // Distance behind the scroll offset, folded back into 0..H_DISPLAY-1 without wrap.
  assign w_dist = (r_h >= r_off) ? (r_h - r_off) : (r_h + (H_DISP - r_off));

  always_comb begin
    w_pix = '0;
    case (r_mode)
      2'd0: w_pix = r_color;
      2'd1: w_pix = w_bar_rgb;
      2'd2: w_pix = (r_h[CHK_LOG2] ^ r_v[CHK_LOG2]) ? r_color : '0;
      default: w_pix = (w_dist < BAR_LEN) ? r_color : '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hsync    <= ~SYNC_POL;
      r_vsync    <= ~SYNC_POL;
      r_video_on <= 1'b0;
      r_rgb      <= '0;
    end else begin
      r_hsync    <= ((r_h >= HS_START) && (r_h < HS_END)) ? SYNC_POL : ~SYNC_POL;
      r_vsync    <= ((r_v >= VS_START) && (r_v < VS_END)) ? SYNC_POL : ~SYNC_POL;
      r_video_on <= w_vis;
      r_rgb      <= w_vis ? w_pix : '0;
    end
  end

  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign video_on   = r_video_on;
  assign rgb        = r_rgb;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a miniature 40x12 raster (32x8 visible, 2 clk/pixel).
module tb_vga_pattern_gen;

  localparam int HD = 32, HF = 2, HS = 4, HB = 2;
  localparam int VD = 8,  VF = 1, VS = 2, VB = 1;
  localparam int DIV = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int PIX = HT * VT;
  localparam int FRAME_CLK = PIX * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [5:0] color;
  logic       hsync, vsync, video_on, frame_tick;
  logic [5:0] rgb;

  vga_pattern_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(DIV), .RGB_W(6), .SYNC_POL(1'b0), .CHK_LOG2(2), .BAR_W(4)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .color(color),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .rgb(rgb),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         key;
    int         f;
    int         x;
    int         y;
    logic [8:0] exp;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int st_frame = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  // Expected {rgb, video_on, hsync, vsync} for pixel (x,y) of frame f.
  task automatic exp_px(input int f, input int x, input int y, input logic [5:0] c,
                        input logic vid, input logic hs, input logic vs);
    exp_t e;
    e.key = f * PIX + y * HT + x;
    e.f = f;
    e.x = x;
    e.y = y;
    e.exp = {c, vid, hs, vs};
    q.push_back(e);
  endtask

  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!frame_tick && cyc < 3 * FRAME_CLK);
    if (!frame_tick) begin
      n_fail++;
      $display("[TB] FAIL frame_tick timeout after %0d clk, expected within %0d", cyc, 3 * FRAME_CLK);
    end
    st_frame++;
  endtask

  // Monitor: locks onto frame_tick, derives the displayed pixel and checks the queue head.
  int  mon_frame = 0;
  int  mon_cnt = 0;
  bit  aligned = 0;
  bit  prev_tick = 0;
  always @(negedge clk) begin
    int pix, key;
    if (reset) begin
      aligned = 0;
    end else if (frame_tick) begin
      if (aligned) chk("frame_tick width", 32'(prev_tick), 32'd0);
      aligned = 1;
      mon_cnt = 0;
      mon_frame++;
    end else if (aligned) begin
      mon_cnt++;
      if ((mon_cnt - 1) % DIV == 0) begin
        pix = (mon_cnt - 1) / DIV;
        key = mon_frame * PIX + pix;
        while (q.size() > 0 && q[0].key < key) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL missed px f%0d (%0d,%0d): never observed, expected %0h",
                   q[0].f, q[0].x, q[0].y, q[0].exp);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].key == key) begin
          chk($sformatf("px f%0d (%0d,%0d) {rgb,vid,hs,vs}", q[0].f, q[0].x, q[0].y),
              32'({rgb, video_on, hsync, vsync}), 32'(q[0].exp));
          void'(q.pop_front());
        end
      end
    end
    prev_tick = frame_tick;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, seen;
    logic [5:0] c1, c_chk, c_all;
    c1 = 6'b110001;
    c_chk = 6'b001100;
    c_all = 6'b111111;
    reset = 1'b1;
    mode = 2'd0;
    color = '0;
    repeat (3) @(negedge clk);
    chk("reset rgb", 32'(rgb), 32'd0);
    chk("reset video_on", 32'(video_on), 32'd0);
    chk("reset hsync", 32'(hsync), 32'd1);
    chk("reset vsync", 32'(vsync), 32'd1);
    chk("reset frame_tick", 32'(frame_tick), 32'd0);
    reset = 1'b0;

    wait_tick(cyc);
    chk("release to first frame_tick", cyc, FRAME_CLK);

    // Solid colour set mid-frame 1: frame 1 stays black, frame 2 shows it.
    exp_px(1, 5, 3, 6'd0, 1, 1, 1);
    exp_px(2, 0, 0, c1, 1, 1, 1);
    exp_px(2, 32, 0, 6'd0, 0, 1, 1);
    exp_px(2, 33, 0, 6'd0, 0, 1, 1);
    exp_px(2, 34, 0, 6'd0, 0, 0, 1);
    exp_px(2, 37, 0, 6'd0, 0, 0, 1);
    exp_px(2, 38, 0, 6'd0, 0, 1, 1);
    exp_px(2, 31, 7, c1, 1, 1, 1);
    exp_px(2, 0, 8, 6'd0, 0, 1, 1);
    exp_px(2, 0, 9, 6'd0, 0, 1, 0);
    exp_px(2, 0, 10, 6'd0, 0, 1, 0);
    exp_px(2, 0, 11, 6'd0, 0, 1, 1);
    repeat (100) @(negedge clk);
    mode = 2'd0;
    color = c1;
    wait_tick(cyc);
    chk("frame period (partial wait)", cyc, FRAME_CLK - 100);

    // Colour bars in frame 3.
    mode = 2'd1;
    exp_px(3, 0, 5, 6'b000000, 1, 1, 1);
    exp_px(3, 3, 5, 6'b000000, 1, 1, 1);
    exp_px(3, 4, 5, 6'b000011, 1, 1, 1);
    exp_px(3, 8, 5, 6'b001100, 1, 1, 1);
    exp_px(3, 12, 5, 6'b001111, 1, 1, 1);
    exp_px(3, 16, 5, 6'b110000, 1, 1, 1);
    exp_px(3, 20, 5, 6'b110011, 1, 1, 1);
    exp_px(3, 24, 5, 6'b111100, 1, 1, 1);
    exp_px(3, 28, 5, 6'b111111, 1, 1, 1);
    exp_px(3, 31, 5, 6'b111111, 1, 1, 1);
    wait_tick(cyc);
    chk("frame period", cyc, FRAME_CLK);

    // Checker (4-pixel squares) in frame 4.
    mode = 2'd2;
    color = c_chk;
    exp_px(4, 0, 0, 6'd0, 1, 1, 1);
    exp_px(4, 4, 0, c_chk, 1, 1, 1);
    exp_px(4, 3, 3, 6'd0, 1, 1, 1);
    exp_px(4, 7, 3, c_chk, 1, 1, 1);
    exp_px(4, 0, 4, c_chk, 1, 1, 1);
    exp_px(4, 4, 4, 6'd0, 1, 1, 1);
    wait_tick(cyc);
    chk("frame period", cyc, FRAME_CLK);

    // Moving bar: offset equals frame number mod 32.
    mode = 2'd3;
    color = c_all;
    exp_px(5, 4, 2, 6'd0, 1, 1, 1);
    exp_px(5, 5, 2, c_all, 1, 1, 1);
    exp_px(5, 8, 2, c_all, 1, 1, 1);
    exp_px(5, 9, 2, 6'd0, 1, 1, 1);
    exp_px(29, 0, 2, c_all, 1, 1, 1);
    exp_px(29, 1, 2, 6'd0, 1, 1, 1);
    exp_px(29, 28, 2, 6'd0, 1, 1, 1);
    exp_px(29, 29, 2, c_all, 1, 1, 1);
    exp_px(29, 31, 2, c_all, 1, 1, 1);
    exp_px(32, 0, 2, c_all, 1, 1, 1);
    exp_px(32, 3, 2, c_all, 1, 1, 1);
    exp_px(32, 4, 2, 6'd0, 1, 1, 1);
    exp_px(32, 31, 2, 6'd0, 1, 1, 1);
    while (st_frame < 33) wait_tick(cyc);
    chk("scoreboard drained", q.size(), 0);

    // Asynchronous reset in the middle of line 1, inside the hsync pulse.
    repeat (151) @(negedge clk);
    chk("hsync active at (35,1)", 32'(hsync), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("async reset hsync", 32'(hsync), 32'd1);
    chk("async reset vsync", 32'(vsync), 32'd1);
    chk("async reset video_on", 32'(video_on), 32'd0);
    chk("async reset rgb", 32'(rgb), 32'd0);
    chk("async reset frame_tick", 32'(frame_tick), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // First frame after reset uses cleared shadows (black), even though mode 3 is applied.
    seen = 0;
    for (int k = 1; k <= 3 * FRAME_CLK; k++) begin
      @(negedge clk);
      if (k == 163) begin
        chk("post-reset (1,2) video_on", 32'(video_on), 32'd1);
        chk("post-reset (1,2) rgb", 32'(rgb), 32'd0);
      end
      if (frame_tick) begin
        seen = k;
        break;
      end
    end
    chk("post-reset first frame_tick clk", seen, FRAME_CLK);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
